// File: rtl/eth_axis_pkg.sv
// rtl/eth_axis_pkg.sv - shared AXI-Stream widths, stored-word layout and drop FSM states
package eth_axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    typedef struct packed {
        logic                   last;
        logic [AXIS_KEEP_W-1:0] keep;
        logic [AXIS_DATA_W-1:0] data;
    } axis_word_t;

    localparam int AXIS_WORD_W = $bits(axis_word_t);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } drop_state_t;

endpackage

// File: rtl/axis_frame_ram_sdp.sv
// rtl/axis_frame_ram_sdp.sv - simple dual-port RAM, one write port and one registered read port
module axis_frame_ram_sdp #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4096,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rd_data holds its value while rd_en is low; the output stage relies on that
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_eth_bad_frame_drop_64.sv
// rtl/axis_eth_bad_frame_drop_64.sv - store-and-forward RX frame FIFO dropping bad and overflowed frames
module axis_eth_bad_frame_drop_64 import eth_axis_pkg::*; #(
    parameter int DEPTH = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   status_good_frame,
    output logic                   status_bad_frame,
    output logic                   status_overflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_W      = ADDR_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t        wr_ptr;
    ptr_t        wr_ptr_cur;
    ptr_t        rd_ptr;
    ptr_t        fill;
    drop_state_t state;
    drop_state_t state_next;
    logic        drop_frame;
    logic        accept;
    logic        full;
    logic        wr_en;
    logic        rd_en;
    logic        pop;
    logic        ram_valid;
    logic        skid_valid;
    axis_word_t  wr_word;
    axis_word_t  ram_rd_word;
    axis_word_t  skid_word;
    axis_word_t  head_word;

    // fill never exceeds DEPTH, so its MSB alone marks the full condition
    assign fill       = wr_ptr_cur - rd_ptr;
    assign full       = fill[ADDR_WIDTH];
    assign drop_frame = (state == ST_DROP);
    assign accept     = s_axis_tvalid && s_axis_tready;
    assign wr_en      = accept && !drop_frame && !full;

    assign wr_word.last = s_axis_tlast;
    assign wr_word.keep = s_axis_tkeep;
    assign wr_word.data = s_axis_tdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            if (s_axis_tlast) begin
                state_next = ST_ACCEPT;
            end else if (full) begin
                state_next = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axis_tready     <= 1'b0;
            wr_ptr            <= '0;
            wr_ptr_cur        <= '0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            s_axis_tready     <= 1'b1;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
            if (accept && s_axis_tlast) begin
                if (drop_frame || full) begin
                    wr_ptr_cur      <= wr_ptr;
                    status_overflow <= 1'b1;
                end else if (s_axis_tuser) begin
                    wr_ptr_cur       <= wr_ptr;
                    status_bad_frame <= 1'b1;
                end else begin
                    wr_ptr            <= wr_ptr_cur + ptr_t'(1);
                    wr_ptr_cur        <= wr_ptr_cur + ptr_t'(1);
                    status_good_frame <= 1'b1;
                end
            end else if (wr_en) begin
                wr_ptr_cur <= wr_ptr_cur + ptr_t'(1);
            end
        end
    end

    axis_frame_ram_sdp #(
        .WIDTH (AXIS_WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_cur[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_word)
    );

    // The RAM read register is the output register; skid holds the older word when both are full
    assign head_word     = skid_valid ? skid_word : ram_rd_word;
    assign m_axis_tvalid = ram_valid || skid_valid;
    assign m_axis_tdata  = head_word.data;
    assign m_axis_tkeep  = head_word.keep;
    assign m_axis_tlast  = head_word.last;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign rd_en         = (rd_ptr != wr_ptr) && !(ram_valid && skid_valid && !pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            ram_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (skid_valid && !pop) begin
                ram_valid <= ram_valid || rd_en;
            end else begin
                skid_valid <= ram_valid && !(pop && !skid_valid);
                skid_word  <= ram_rd_word;
                ram_valid  <= rd_en;
            end
        end
    end

endmodule

// File: tb/tb_axis_eth_bad_frame_drop_64.sv
// tb/tb_axis_eth_bad_frame_drop_64.sv - self-checking bench with a frame-level reference model
module tb_axis_eth_bad_frame_drop_64;

    localparam int DEPTH = 16;

    typedef logic [72:0] word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        status_good_frame;
    logic        status_bad_frame;
    logic        status_overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int   ready_mode = 0;
    logic ready_const = 1'b1;

    word_t      exp_q[$];
    word_t      cur_q[$];
    logic [2:0] pend = 3'b000;
    logic       rst_prev = 1'b0;
    logic       held = 1'b0;
    word_t      held_word = '0;
    int         cnt_good = 0;
    int         cnt_bad = 0;
    int         cnt_ovf = 0;

    axis_eth_bad_frame_drop_64 #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .status_good_frame (status_good_frame),
        .status_bad_frame  (status_bad_frame),
        .status_overflow   (status_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_axis_tready = ready_const;
            else if (ready_mode == 1) m_axis_tready = ~m_axis_tready;
            else m_axis_tready = ($urandom_range(0, 1) == 1);
        end
    end

    // Reference model: a frame is buffered whole, then released, rejected (tuser) or lost (too long)
    always @(negedge clk) begin
        word_t act;
        act = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};

        checks++;
        if ({status_good_frame, status_bad_frame, status_overflow} !== pend) begin
            failures++;
            $display("FAIL status: got %b required %b (good,bad,ovf) cycle %0d",
                     {status_good_frame, status_bad_frame, status_overflow}, pend, cyc);
        end
        if (rst_prev) begin
            cnt_good += int'(status_good_frame);
            cnt_bad  += int'(status_bad_frame);
            cnt_ovf  += int'(status_overflow);
        end
        checks++;
        if (s_axis_tready !== rst_prev) begin
            failures++;
            $display("FAIL s_tready: got %b required %b cycle %0d", s_axis_tready, rst_prev, cyc);
        end
        if (!rst_prev) begin
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_tvalid: got %b required 0 cycle %0d", m_axis_tvalid, cyc);
            end
        end

        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || act !== held_word) begin
                    failures++;
                    $display("FAIL stall_stable: got v=%b %h required v=1 %h cycle %0d",
                             m_axis_tvalid, act, held_word, cyc);
                end
            end
            if (m_axis_tvalid === 1'b1) begin
                if (m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected: got %h required no word cycle %0d", act, cyc);
                    end else begin
                        if (act !== exp_q[0]) begin
                            failures++;
                            $display("FAIL out_word: got %h required %h cycle %0d", act, exp_q[0], cyc);
                        end
                        void'(exp_q.pop_front());
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_word = act;
                end
            end else begin
                held = 1'b0;
            end
        end

        pend = 3'b000;
        if (!rst_n) begin
            exp_q.delete();
            cur_q.delete();
        end else if (rst_prev && s_axis_tvalid) begin
            cur_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
            if (s_axis_tlast) begin
                if (cur_q.size() > DEPTH) pend = 3'b001;
                else if (s_axis_tuser) pend = 3'b010;
                else begin
                    pend = 3'b100;
                    exp_q = {exp_q, cur_q};
                end
                cur_q.delete();
            end
        end
        rst_prev = rst_n;
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic set_ready(input int mode, input logic val);
        ready_mode = mode;
        ready_const = val;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int fid, input int len, input logic [7:0] last_keep, input logic user);
        for (int i = 0; i < len; i++) begin
            send_word({16'hCAFE, 16'(fid), 32'(i)}, (i == len - 1) ? last_keep : 8'hFF,
                      (i == len - 1), (i == len - 1) ? user : 1'b0);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || m_axis_tvalid) begin
            failures++;
            $display("FAIL drain_%s: %0d words pending, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (4) @(posedge clk);
        #1;
        check_lit("reset_tready", 64'(s_axis_tready), 64'h0);
        check_lit("reset_tvalid", 64'(m_axis_tvalid), 64'h0);
        check_lit("reset_status", 64'({status_good_frame, status_bad_frame, status_overflow}), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_lit("tready_after_reset", 64'(s_axis_tready), 64'h1);

        send_frame(1, 8, 8'h0F, 1'b0);
        @(negedge clk);
        check_lit("t1_lat_n1_tvalid", 64'(m_axis_tvalid), 64'h0);
        @(negedge clk);
        check_lit("t1_lat_n2_tvalid", 64'(m_axis_tvalid), 64'h1);
        check_lit("t1_first_tdata", m_axis_tdata, 64'hCAFE_0001_0000_0000);
        check_lit("t1_first_tlast", 64'(m_axis_tlast), 64'h0);
        drain("t1");

        send_frame(2, 5, 8'hFF, 1'b1);
        send_frame(3, 3, 8'h07, 1'b0);
        drain("t2");

        set_ready(0, 1'b0);
        send_frame(4, 20, 8'hFF, 1'b0);
        @(negedge clk);
        check_lit("t3_overflow_pulse", 64'(status_overflow), 64'h1);
        check_lit("t3_no_output", 64'(m_axis_tvalid), 64'h0);
        set_ready(0, 1'b1);
        send_frame(5, 4, 8'h3F, 1'b0);
        drain("t3");

        set_ready(1, 1'b0);
        for (int f = 0; f < 12; f++) send_frame(10 + f, 1, 8'h01, 1'b0);
        drain("t4");

        set_ready(2, 1'b0);
        for (int f = 0; f < 50; f++) begin
            n = 0;
            while (exp_q.size() > 8 && n < 200) begin
                @(posedge clk);
                #2;
                n++;
            end
            if (n >= 200) begin
                checks++;
                failures++;
                $display("FAIL t5_throttle: %0d words pending, required <= 8", exp_q.size());
            end
            send_frame(100 + f, 3, 8'hFF >> (f % 8), 1'b0);
        end
        drain("t5");

        set_ready(0, 1'b0);
        send_frame(200, 2, 8'hFF, 1'b0);
        send_word({16'hCAFE, 16'd201, 32'd0}, 8'hFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check_lit("t6_pending_tvalid", 64'(m_axis_tvalid), 64'h1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_lit("t6_reset_tvalid", 64'(m_axis_tvalid), 64'h0);
        check_lit("t6_reset_tready", 64'(s_axis_tready), 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_ready(0, 1'b1);
        send_frame(202, 2, 8'h03, 1'b0);
        drain("t6");
        repeat (3) @(posedge clk);
        #2;

        check_lit("count_good", 64'(cnt_good), 64'd67);
        check_lit("count_bad", 64'(cnt_bad), 64'd1);
        check_lit("count_ovf", 64'(cnt_ovf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
